// File: rtl/conv_pkg.sv
// Shared convolution constants and fetch state encoding.
// Used by the IFM window fetch path and its output register.
package conv_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 26;
  localparam int FMAP_DIM   = 64;
  localparam int KERNEL_DIM = 4;
  localparam int WIN_PIX    = KERNEL_DIM * KERNEL_DIM;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/ifm_win_outreg.sv
// Output holding register for assembled windows.
// Holds data stable until out_valid/out_ready handshake.
module ifm_win_outreg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         free
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Free when empty or draining this cycle, so reload needs no bubble.
  assign free      = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/ifm_window_fetch.sv
// Gathers WIN_PIX feature-map reads into one window for the MAC array.
// Define IFM_FETCH_STATS_EN to add the saturating stall_cnt output.
module ifm_window_fetch #(
  parameter int DATA_W  = conv_pkg::DATA_W,
  parameter int ADDR_W  = conv_pkg::ADDR_W,
  parameter int WIN_PIX = conv_pkg::WIN_PIX
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_conv,
  input  logic                      end_conv,
  input  logic                      addr_valid,
  input  logic [ADDR_W-1:0]         addr,
  output logic                      addr_ready,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      win_valid,
  output logic [WIN_PIX*DATA_W-1:0] win_data,
  input  logic                      win_ready,
  output logic [15:0]               win_cnt
`ifdef IFM_FETCH_STATS_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  import conv_pkg::*;

  localparam int CNT_W = $clog2(WIN_PIX + 1);
  localparam int WIN_W = WIN_PIX * DATA_W;
  localparam logic [CNT_W-1:0] PIX_N = CNT_W'(WIN_PIX);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIN_PIX - 1);

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic [WIN_W-1:0] asm_q, asm_d;
  logic [15:0]      win_cnt_q, win_cnt_d;

  logic accept;
  logic ret_en;
  logic win_done;
  logic out_free;
  logic xfer;
  logic stop;
  logic hs;

  assign stop       = (state_q != IDLE) && !start_conv;
  assign addr_ready = (state_q == RUN) && (issue_cnt_q < PIX_N)
                      && !end_conv;
  assign accept     = addr_valid && addr_ready;
  assign mem_rd_en  = accept;
  assign mem_addr   = accept ? addr : '0;
  assign ret_en     = rd_pend_q && !end_conv;
  // Full either on the last returning lane or while parked in HOLD.
  assign win_done   = (ret_en && ret_cnt_q == LAST) || (state_q == HOLD);
  assign xfer       = win_done && out_free && !end_conv && !stop;
  assign hs         = win_valid && win_ready;
  assign win_cnt    = win_cnt_q;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    rd_pend_d   = accept;
    asm_d       = asm_q;
    win_cnt_d   = win_cnt_q + {15'd0, hs};
    unique case (state_q)
      IDLE: if (start_conv) state_d = RUN;
      RUN: begin
        if (win_done && !out_free && !end_conv) state_d = HOLD;
      end
      HOLD: if (out_free || end_conv) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (accept) issue_cnt_d = issue_cnt_q + CNT_W'(1);
    for (int k = 0; k < WIN_PIX; k++) begin
      if (ret_en && ret_cnt_q == CNT_W'(k))
        asm_d[k*DATA_W +: DATA_W] = mem_rdata;
    end
    if (ret_en) ret_cnt_d = ret_cnt_q + CNT_W'(1);
    if (xfer || end_conv) begin
      issue_cnt_d = '0;
      ret_cnt_d   = '0;
    end
    if (end_conv) rd_pend_d = 1'b0;
    // Dropping start_conv outranks any handshake in the same cycle.
    if (stop) begin
      state_d     = IDLE;
      issue_cnt_d = '0;
      ret_cnt_d   = '0;
      rd_pend_d   = 1'b0;
      win_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      asm_q       <= '0;
      win_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      rd_pend_q   <= rd_pend_d;
      asm_q       <= asm_d;
      win_cnt_q   <= win_cnt_d;
    end
  end

  ifm_win_outreg #(
    .W(WIN_W)
  ) u_outreg (
    .clk      (clk),
    .rst      (rst),
    .clr      (stop),
    .load     (xfer),
    .load_data(asm_d),
    .out_ready(win_ready),
    .out_valid(win_valid),
    .out_data (win_data),
    .free     (out_free)
  );

`ifdef IFM_FETCH_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (win_valid && !win_ready && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifm_window_fetch.sv
// Randomized and directed bench for ifm_window_fetch.
// Scoreboard groups accepted addresses into windows of SRAM data.
module tb_ifm_window_fetch;

  import conv_pkg::*;

  localparam int DW = 8;
  localparam int AW = 26;
  localparam int NP = 16;
  localparam int WB = NP * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_conv;
  logic          end_conv;
  logic          addr_valid;
  logic [AW-1:0] addr;
  logic          addr_ready;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          win_valid;
  logic [WB-1:0] win_data;
  logic          win_ready;
  logic [15:0]   win_cnt;
`ifdef IFM_FETCH_STATS_EN
  logic [31:0]   stall_cnt;
`endif

  ifm_window_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .start_conv(start_conv),
    .end_conv  (end_conv),
    .addr_valid(addr_valid),
    .addr      (addr),
    .addr_ready(addr_ready),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .win_valid (win_valid),
    .win_data  (win_data),
    .win_ready (win_ready),
    .win_cnt   (win_cnt)
`ifdef IFM_FETCH_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [AW-1:0] grp[$];
  logic [WB-1:0] expq[$];
  int            hs_cycs[$];
  logic [15:0]   exp_cnt;
  int            n_chk, n_err, cyc, acc_total;
  int            first_acc, first_win;
  logic          pend_rd;
  logic [AW-1:0] pend_addr;
  logic          prev_valid, prev_ready, prev_stop;
  logic [WB-1:0] prev_data, last_win, ref_win;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16];
  endfunction

  task automatic chk(input string tag, input logic [WB-1:0] obs,
                     input logic [WB-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flush_model();
    grp.delete();
    expq.delete();
    exp_cnt    = '0;
    prev_valid = 1'b0;
  endtask

  task automatic tick();
    logic          acc;
    logic [WB-1:0] w;
    #1;
    acc = addr_valid && addr_ready;
    chk("rd_en", mem_rd_en, acc);
    if (end_conv) chk("ready_in_end", addr_ready, 0);
    if (acc) begin
      chk("rd_addr", mem_addr, addr);
      acc_total++;
      if (first_acc < 0) first_acc = cyc;
      grp.push_back(addr);
      if (grp.size() == NP) begin
        w = '0;
        for (int k = 0; k < NP; k++) w[k*DW +: DW] = mem_f(grp[k]);
        expq.push_back(w);
        grp.delete();
      end
    end
    if (win_valid && first_win < 0) first_win = cyc;
    if (prev_valid && !prev_ready && !prev_stop) begin
      chk("hold_valid", win_valid, 1);
      chk("hold_data", win_data, prev_data);
    end
    if (win_valid && win_ready) begin
      hs_cycs.push_back(cyc);
      last_win = win_data;
      chk("win_expected", expq.size() != 0, 1);
      if (expq.size() != 0) chk("win_data", win_data, expq.pop_front());
      chk("win_cnt", win_cnt, exp_cnt);
      exp_cnt++;
    end
    prev_valid = win_valid;
    prev_ready = win_ready;
    prev_data  = win_data;
    prev_stop  = !start_conv || rst;
    pend_rd    = acc;
    pend_addr  = addr;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    mem_rdata = pend_rd ? mem_f(pend_addr) : DW'($urandom);
  endtask

  task automatic feed(input int n, input int base, input bit rnd);
    int s;
    int budget;
    int i;
    s = acc_total;
    budget = 400;
    addr_valid = 1'b1;
    while (acc_total - s < n && budget > 0) begin
      i = acc_total - s;
      addr = rnd ? AW'($urandom) : AW'(base + (i / 4) * 64 + i % 4);
      tick();
      budget--;
    end
    addr_valid = 1'b0;
    chk("feed_cnt", 32'(acc_total - s), 32'(n));
  endtask

  task automatic wait_win();
    int budget;
    budget = 500;
    while (expq.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain", 32'(expq.size()), 0);
  endtask

  task automatic restart();
    addr_valid = 1'b0;
    start_conv = 1'b0;
    tick();
    tick();
    flush_model();
    start_conv = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start_conv = 1'b0;
    end_conv = 1'b0;
    addr_valid = 1'b1;
    addr = AW'(5);
    win_ready = 1'b1;
    mem_rdata = '0;
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    acc_total = 0;
    first_acc = -1;
    first_win = -1;
    pend_rd = 1'b0;
    pend_addr = '0;
    prev_stop = 1'b1;
    last_win = '0;
    flush_model();

    @(negedge clk);
    #1;
    chk("rst_addr_ready", addr_ready, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_win_cnt", win_cnt, 0);
    chk("rst_state", dut.state_q == IDLE, 1);
    rst = 1'b0;
    tick();
    tick();
    #1;
    chk("idle_ready", addr_ready, 0);

    // Single window with addr[7:0] data.
    start_conv = 1'b1;
    first_acc = -1;
    first_win = -1;
    feed(NP, 0, 1'b0);
    wait_win();
    chk("latency", 32'(first_win - first_acc), 32'(NP + 1));
    chk("win_cnt_1", win_cnt, 1);
    ref_win = '0;
    for (int k = 0; k < NP; k++)
      ref_win[k*DW +: DW] = DW'((k / 4) * 8'h40 + k % 4);
    chk("single_win", last_win, ref_win);

    // Back-to-back throughput.
    restart();
    hs_cycs.delete();
    feed(2 * NP, 2048, 1'b0);
    wait_win();
    chk("period", 32'(hs_cycs[1] - hs_cycs[0]), 32'(NP + 1));

    // Back-pressure across two windows.
    restart();
    win_ready = 1'b0;
    feed(2 * NP, 4096, 1'b0);
    addr_valid = 1'b1;
    addr = AW'(4096 + 512);
    repeat (3) tick();
    #1;
    chk("hold_state", dut.state_q == HOLD, 1);
    chk("hold_ready", addr_ready, 0);
    chk("hold_pending", 32'(expq.size()), 2);
    addr_valid = 1'b0;
    win_ready = 1'b1;
    wait_win();

    // end_conv drops a partial window.
    restart();
    feed(7, 8192, 1'b0);
    end_conv = 1'b1;
    addr_valid = 1'b1;
    addr = AW'(9000);
    tick();
    grp.delete();
    repeat (5) begin
      tick();
      chk("no_win", win_valid, 0);
    end
    end_conv = 1'b0;
    restart();
    feed(NP, 12288, 1'b0);
    wait_win();

    // Randomized traffic with random back-pressure.
    restart();
    repeat (800) begin
      addr_valid = ($urandom_range(3) != 0);
      addr = AW'($urandom);
      win_ready = ($urandom_range(2) != 0);
      tick();
    end
    addr_valid = 1'b0;
    win_ready = 1'b1;
    wait_win();

    // Reset mid-window.
    restart();
    feed(10, 16384, 1'b0);
    addr_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("mrst_addr_ready", addr_ready, 0);
    chk("mrst_rd_en", mem_rd_en, 0);
    chk("mrst_mem_addr", mem_addr, 0);
    chk("mrst_win_valid", win_valid, 0);
    chk("mrst_win_data", win_data, 0);
    chk("mrst_win_cnt", win_cnt, 0);
    flush_model();
    addr_valid = 1'b0;
    tick();
    rst = 1'b0;
    flush_model();
`ifdef IFM_FETCH_STATS_EN
    chk("stall_rst", stall_cnt, 0);
`endif
    win_ready = 1'b0;
    feed(NP, 20480, 1'b0);
    begin
      int budget;
      budget = 50;
      while (!win_valid && budget > 0) begin
        tick();
        budget--;
      end
    end
    chk("stall_win", win_valid, 1);
    repeat (5) tick();
`ifdef IFM_FETCH_STATS_EN
    chk("stall_cnt", stall_cnt, 5);
`endif
    win_ready = 1'b1;
    wait_win();

    // win_cnt wrap.
    force dut.win_cnt_q = 16'hFFFF;
    #1;
    release dut.win_cnt_q;
    exp_cnt = 16'hFFFF;
    feed(NP, 24576, 1'b0);
    wait_win();
    chk("win_cnt_wrap", win_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
